instr_encoder: RTL
==================

// Module: instr_encoder
// PURPOSE
//  Packs RV32I instruction descriptors (opcode class, registers, funct3, arith bit, immediate) into 32-bit machine words.
//  It is the inverse of the core's instruction decoder and drives it from test/boot logic.
//  A valid/ready input accepts descriptors; encoded words are buffered in an internal FIFO.
//  The FIFO is drained by a valid/ready output, typically into instruction memory or a fetch-injection port.
// PARAMETERS
//  DEPTH   4   output FIFO entries; power of 2, >= 2
//  ADDR_W  $clog2(DEPTH)   derived (localparam), FIFO pointer width
// PORTS
//  clk        in   1         clock, rising edge
//  reset      in   1         asynchronous, active-high reset
//  in_valid   in   1         descriptor valid
//  in_ready   out  1         descriptor accepted when in_valid && in_ready
//  in_opcode  in   5         instruction[6:2] class: OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC
//  in_funct3  in   3         funct3 field
//  in_arith   in   1         SUB/SRA select (instruction[30])
//  in_rd      in   5         destination register
//  in_rs1     in   5         source register 1
//  in_rs2     in   5         source register 2
//  in_imm     in   32        full signed byte-offset / value immediate
//  out_valid  out  1         FIFO head valid
//  out_ready  in   1         pop when out_valid && out_ready
//  out_instr  out  32        encoded word at FIFO head
//  out_err    out  1         head entry was illegal (encoded as NOP)
//  level      out  ADDR_W+1  current FIFO occupancy
// BEHAVIOUR
//  - Reset (async): FIFO flushed, pointers 0; level=0, out_valid=0, in_ready=1, out_instr=0, out_err=0.
//  - Every output word has bits[1:0]=2'b11 and bits[6:2]=in_opcode.
//  - Encoding is combinational on the accepted descriptor and written to the FIFO on the same edge.
//    The word is visible at out_* one cycle after acceptance (latency 1).
//  - Formats (rd=[11:7], f3=[14:12], rs1=[19:15], rs2=[24:20]):
//    OP:     funct7 = (in_arith && f3 in {000,101}) ? 7'b0100000 : 0.
//    OP_IMM: imm[11:0]; for f3=001/101, [31:25] = {1'b0, in_arith(101 only), 5'b0} and [24:20] = imm[4:0].
//    LOAD, JALR: imm[11:0]; JALR forces f3=000.
//    STORE:  [31:25]=imm[11:5], [11:7]=imm[4:0].
//    BRANCH: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11]}.
//    LUI, AUIPC: [31:12]=imm[31:12].
//    JAL:    {imm[20], imm[10:1], imm[11], imm[19:12]}, then rd.
//    Unused register fields are 0.
//  - Unknown in_opcode: word = NOP 32'h00000013, err=1.
//  - in_ready = (level != DEPTH); no write-through when full.
//  - Full plus simultaneous pop: in_ready stays 0 that cycle; the push is taken the following cycle.
//  - Simultaneous push+pop when not full: level unchanged; order preserved (FIFO).
//  - Pointers wrap modulo DEPTH; level saturates neither way. Pop when empty or push when full is ignored.
//  - out_instr/out_err hold the head entry while out_valid && !out_ready (stable until popped).
// CONFIGURATION
//  IMM_RANGE_CHECK_EN defined:
//    Immediates are range-checked per format:
//      - I/S: imm must sign-fit in 12 bits.
//      - B: must sign-fit in 13 bits with imm[0]=0.
//      - J: must sign-fit in 21 bits with imm[0]=0.
//      - U: imm[11:0]=0.
//      - Shifts: imm[31:5]=0.
//    A violation stores NOP 32'h00000013 with err=1.
//  Not defined: no checks; imm bits outside the field are silently dropped. err=1 only for unknown opcode.
// TESTING
//  1. OP_IMM f3=000 rd=1 rs1=0 imm=5 -> next cycle out_instr=32'h00500093, out_err=0, level=1.
//  2. OP f3=000 arith=1 rd=3 rs1=1 rs2=2 -> 32'h402081B3.
//     STORE f3=010 rs1=1 rs2=2 imm=8 -> 32'h0020A423.
//  3. BRANCH f3=000 rs1=1 rs2=2 imm=-4 -> 32'hFE208EE3.
//     JAL rd=1 imm=32'h800 -> 32'h001000EF.
//  4. OP_IMM imm=2048 rd=1 -> with IMM_RANGE_CHECK_EN: 32'h00000013 err=1; without: 32'h80000093 err=0.
//     Opcode 5'b11111 -> NOP err=1.
//  5. DEPTH=4, out_ready=0, push 5 descriptors back-to-back:
//     - after 4 accepted, in_ready=0 and level=4, 5th held.
//     - then out_ready=1 -> 5 words in order; the 5th is accepted the cycle after the first pop.
//  6. Assert reset mid-stream with level=3 -> same cycle level=0, out_valid=0.
//     After release, first push emerges cleanly.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32I instruction descriptors into 32-bit machine words
// and queues them in a small output FIFO drained by a valid/ready port.
//
// Optional build macro IMM_RANGE_CHECK_EN: when defined, immediates that do
// not fit their format are rejected and replaced by a NOP flagged with err=1.
// When undefined, out-of-field immediate bits are silently dropped.

module instr_encoder #(
    parameter  int DEPTH  = 4,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_opcode,
    input  logic [2:0]        in_funct3,
    input  logic              in_arith,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic              out_err,
    output logic [ADDR_W:0]   level
);

    // instruction[6:2] opcode classes
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    localparam logic [31:0]     NOP  = 32'h0000_0013;
    localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);

    typedef struct packed {
        logic        err;
        logic [31:0] instr;
    } entry_t;

    entry_t            mem [DEPTH];
    entry_t            enc;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   cnt;
    logic              push;
    logic              pop;

    logic [31:0] word;
    logic        known;
    logic        imm_ok;
    logic        is_shift;

    // per-format immediate fit flags
    logic fit_i;
    logic fit_b;
    logic fit_j;
    logic fit_u;
    logic fit_sh;

`ifdef IMM_RANGE_CHECK_EN
    // sign-fit means every bit above the field's sign bit equals the sign bit
    assign fit_i  = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign fit_b  = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
    assign fit_j  = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];
    assign fit_u  = ~(|in_imm[11:0]);
    assign fit_sh = ~(|in_imm[31:5]);
`else
    assign fit_i  = 1'b1;
    assign fit_b  = 1'b1;
    assign fit_j  = 1'b1;
    assign fit_u  = 1'b1;
    assign fit_sh = 1'b1;
`endif

    assign is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

    // format the descriptor into a word; illegal descriptors collapse to a flagged NOP
    always_comb begin
        word   = '0;
        known  = 1'b1;
        imm_ok = 1'b1;
        case (in_opcode)
            OPC_OP: begin
                word = {1'b0,
                        in_arith && (in_funct3 == 3'b000 || in_funct3 == 3'b101),
                        5'b0, in_rs2, in_rs1, in_funct3, in_rd, in_opcode, 2'b11};
            end
            OPC_OP_IMM: begin
                if (is_shift) begin
                    // shamt lives in rs2's slot; only SRAI carries the arith bit
                    word   = {1'b0, in_arith && (in_funct3 == 3'b101), 5'b0,
                              in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode, 2'b11};
                    imm_ok = fit_sh;
                end else begin
                    word   = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode, 2'b11};
                    imm_ok = fit_i;
                end
            end
            OPC_LOAD: begin
                word   = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode, 2'b11};
                imm_ok = fit_i;
            end
            OPC_JALR: begin
                word   = {in_imm[11:0], in_rs1, 3'b000, in_rd, in_opcode, 2'b11};
                imm_ok = fit_i;
            end
            OPC_STORE: begin
                word   = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0],
                          in_opcode, 2'b11};
                imm_ok = fit_i;
            end
            OPC_BRANCH: begin
                word   = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                          in_imm[4:1], in_imm[11], in_opcode, 2'b11};
                imm_ok = fit_b;
            end
            OPC_LUI, OPC_AUIPC: begin
                word   = {in_imm[31:12], in_rd, in_opcode, 2'b11};
                imm_ok = fit_u;
            end
            OPC_JAL: begin
                word   = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                          in_rd, in_opcode, 2'b11};
                imm_ok = fit_j;
            end
            default: begin
                known = 1'b0;
            end
        endcase
    end

    // select between the formatted word and the flagged NOP
    always_comb begin
        enc.err   = 1'b1;
        enc.instr = NOP;
        if (known && imm_ok) begin
            enc.err   = 1'b0;
            enc.instr = word;
        end
    end

    // handshake qualification; a full FIFO never accepts even when popping
    assign in_ready  = (cnt != FULL);
    assign out_valid = (cnt != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign level     = cnt;

    // outputs read as zero while empty so reset shows a clean bus
    assign out_instr = out_valid ? mem[rd_ptr].instr : '0;
    assign out_err   = out_valid ? mem[rd_ptr].err   : 1'b0;

    // storage write on accept; flushed by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wr_ptr] <= enc;
        end
    end

    // pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // occupancy tracks push/pop; both together leave it unchanged
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule
